// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD ratio reducer.
// Holds the default datapath width and the FSM state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        DIV1,
        DIV2,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// done pulses during the final iteration with the finished quotient/remainder.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    // One restoring step: shift in next dividend bit, subtract when it fits
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = ~diff[WIDTH];
        rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {quo[WIDTH-2:0], ge};
    end

    // Last step is in flight when one iteration remains
    always_comb begin
        done      = busy && (cnt == CW'(1));
        quotient  = quo_n;
        remainder = rem_n;
    end

    // Load operands on start, then iterate until the count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
            cnt  <= CW'(WIDTH);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= rem_n;
            quo  <= quo_n;
            cnt  <= cnt - CW'(1);
            busy <= (cnt != CW'(1));
        end
    end

endmodule

// File: rtl/gcd_ratio_reducer.sv
// Divides an operand pair by its GCD using one shared sequential divider.
// Reports floor quotients and flags a zero or non-dividing GCD.
module gcd_ratio_reducer
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [WIDTH-1:0] gcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] red1,
    output logic [WIDTH-1:0] red2,
    output logic             div_err
);

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] gcd_q;

    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    logic             accept;

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; DIV2 spends one handoff cycle starting the divider
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid) state_n = (gcd == '0) ? DONE : DIV1;
            DIV1: if (div_done) state_n = DIV2;
            DIV2: if (div_done) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake and divider control; first division uses the live inputs
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        accept       = in_ready && in_valid;
        div_start    = (accept && (gcd != '0))
                    || ((state == DIV2) && !div_busy);
        div_dividend = (state == IDLE) ? num1 : op2;
        div_divisor  = (state == IDLE) ? gcd : gcd_q;
    end

    // Operand latch and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op2     <= '0;
            gcd_q   <= '0;
            red1    <= '0;
            red2    <= '0;
            div_err <= 1'b0;
        end else if (accept) begin
            op2     <= num2;
            gcd_q   <= gcd;
            red1    <= '0;
            red2    <= '0;
            div_err <= (gcd == '0);
        end else if (div_done && (state == DIV1)) begin
            red1    <= div_quo;
            div_err <= div_err | (div_rem != '0);
        end else if (div_done && (state == DIV2)) begin
            red2    <= div_quo;
            div_err <= div_err | (div_rem != '0);
        end
    end

endmodule

// File: tb/tb_gcd_ratio_reducer.sv
// Self-checking bench for gcd_ratio_reducer.
// Directed cases plus random triples against an arithmetic reference.
module tb_gcd_ratio_reducer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] num1 = '0;
    logic [W-1:0] num2 = '0;
    logic [W-1:0] gcd = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] red1;
    logic [W-1:0] red2;
    logic         div_err;

    int errors = 0;
    int checks = 0;

    gcd_ratio_reducer #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num1     (num1),
        .num2     (num2),
        .gcd      (gcd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .red1     (red1),
        .red2     (red2),
        .div_err  (div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one triple, measure latency, compare against plain arithmetic
    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] g,
                       input bit drain);
        logic [W-1:0] e1, e2;
        logic         ee;
        int           lat, elat;
        e1   = (g == 0) ? '0 : a / g;
        e2   = (g == 0) ? '0 : b / g;
        ee   = (g == 0) || (a % g != 0) || (b % g != 0);
        elat = (g == 0) ? 1 : 2 * W + 1;
        @(negedge clk);
        chk({tag, ".in_ready"}, W'(in_ready), W'(1));
        num1 = a; num2 = b; gcd = g; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num1 = $urandom; num2 = $urandom; gcd = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        chk({tag, ".latency"}, W'(lat), W'(elat));
        chk({tag, ".red1"}, red1, e1);
        chk({tag, ".red2"}, red2, e2);
        chk({tag, ".err"}, W'(div_err), W'(ee));
        if (drain) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, ".ov_fall"}, W'(out_valid), W'(0));
            chk({tag, ".ir_rise"}, W'(in_ready), W'(1));
        end
    endtask

    initial begin
        logic [W-1:0] a, b, g, h1, h2;
        logic         he;

        #12;
        chk("rst.in_ready", W'(in_ready), W'(1));
        chk("rst.out_valid", W'(out_valid), W'(0));
        chk("rst.red1", red1, '0);
        chk("rst.red2", red2, '0);
        chk("rst.err", W'(div_err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run("basic", 12, 18, 6, 1);
        run("zero_num", 0, 5, 5, 1);
        run("zero_gcd", 0, 0, 0, 1);
        run("nondiv", 12, 18, 5, 1);
        run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run("zero_gcd_nz", 7, 9, 0, 1);

        for (int i = 0; i < 8; i++) begin
            g = W'($urandom_range(1, 65535));
            a = g * W'($urandom_range(0, 65535));
            b = g * W'($urandom_range(0, 65535));
            if (i % 3 == 1) a = $urandom;
            if (i % 4 == 3) g = $urandom;
            run($sformatf("rand%0d", i), a, b, g, 1);
        end

        // Backpressure: hold result, offer a new triple that must be ignored
        run("bp", 100, 75, 25, 0);
        h1 = red1; h2 = red2; he = div_err;
        @(negedge clk);
        num1 = 8; num2 = 4; gcd = 4; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp.ov%0d", i), W'(out_valid), W'(1));
            chk($sformatf("bp.ir%0d", i), W'(in_ready), W'(0));
            chk($sformatf("bp.r1_%0d", i), red1, h1);
            chk($sformatf("bp.r2_%0d", i), red2, h2);
            chk($sformatf("bp.e%0d", i), W'(div_err), W'(he));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp.ov_fall", W'(out_valid), W'(0));
        chk("bp.ir_rise", W'(in_ready), W'(1));
        chk("bp.hold_r1", red1, h1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp.no_accept", W'(in_ready), W'(1));

        // Reset in the middle of the first division
        @(negedge clk);
        num1 = 100; num2 = 50; gcd = 5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid.busy", W'(in_ready), W'(0));
        rst_n = 1'b0;
        #1;
        chk("mid.ov", W'(out_valid), W'(0));
        chk("mid.ir", W'(in_ready), W'(1));
        chk("mid.r1", red1, '0);
        chk("mid.r2", red2, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk("mid.no_pulse", W'(out_valid), W'(0));
        run("after_rst", 21, 14, 7, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
